// File: rtl/friscv_rd_arbiter.sv
// Write-back arbiter and register scoreboard for the friscv integer register file.
// Optional macro FRISCV_RR_ARB_EN selects round-robin arbitration; default is fixed csr>memfy>alu.
module friscv_rd_arbiter #(
    parameter int XLEN  = 32,
    parameter int RV32E = 0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd_addr,
    input  logic [4:0]        chk_rs1_addr,
    input  logic [4:0]        chk_rs2_addr,
    input  logic [4:0]        chk_rd_addr,
    output logic              chk_hazard,
    output logic              sb_empty,
    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [4:0]        alu_wb_addr,
    input  logic [XLEN-1:0]   alu_wb_val,
    input  logic [XLEN/8-1:0] alu_wb_strb,
    input  logic              memfy_wb_valid,
    output logic              memfy_wb_ready,
    input  logic [4:0]        memfy_wb_addr,
    input  logic [XLEN-1:0]   memfy_wb_val,
    input  logic [XLEN/8-1:0] memfy_wb_strb,
    input  logic              csr_wb_valid,
    output logic              csr_wb_ready,
    input  logic [4:0]        csr_wb_addr,
    input  logic [XLEN-1:0]   csr_wb_val,
    output logic              rf_rd_wr,
    output logic [4:0]        rf_rd_addr,
    output logic [XLEN-1:0]   rf_rd_val,
    output logic [XLEN/8-1:0] rf_rd_strb
);

    // Handshake: a transfer happens on valid & ready; requesters hold valid and
    // payload stable until ready. Ready is combinational and one-hot (or zero).
    logic [2:0]        wb_valid;
    logic [2:0]        grant;
    logic              any_grant;
    logic [4:0]        sel_addr;
    logic [XLEN-1:0]   sel_val;
    logic [XLEN/8-1:0] sel_strb;
    logic [31:0]       pending;
    logic [31:0]       pending_nxt;

    assign wb_valid = {csr_wb_valid, memfy_wb_valid, alu_wb_valid};

`ifdef FRISCV_RR_ARB_EN
    logic [1:0] rr_ptr;

    // rr_ptr names the requester with highest priority this cycle.
    always_comb begin
        grant = 3'b000;
        case (rr_ptr)
            2'd0:    grant = wb_valid[0] ? 3'b001 : wb_valid[1] ? 3'b010 : wb_valid[2] ? 3'b100 : 3'b000;
            2'd1:    grant = wb_valid[1] ? 3'b010 : wb_valid[2] ? 3'b100 : wb_valid[0] ? 3'b001 : 3'b000;
            default: grant = wb_valid[2] ? 3'b100 : wb_valid[0] ? 3'b001 : wb_valid[1] ? 3'b010 : 3'b000;
        endcase
        if (!aresetn) grant = 3'b000;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn)      rr_ptr <= 2'd0;
        else if (grant[0]) rr_ptr <= 2'd1;
        else if (grant[1]) rr_ptr <= 2'd2;
        else if (grant[2]) rr_ptr <= 2'd0;
    end
`else
    always_comb begin
        grant = 3'b000;
        if (wb_valid[2])      grant = 3'b100;
        else if (wb_valid[1]) grant = 3'b010;
        else if (wb_valid[0]) grant = 3'b001;
        if (!aresetn) grant = 3'b000;
    end
`endif

    assign alu_wb_ready   = grant[0];
    assign memfy_wb_ready = grant[1];
    assign csr_wb_ready   = grant[2];
    assign any_grant      = |grant;

    always_comb begin
        sel_addr = '0;
        sel_val  = '0;
        sel_strb = '0;
        if (grant[0]) begin
            sel_addr = alu_wb_addr;
            sel_val  = alu_wb_val;
            sel_strb = alu_wb_strb;
        end
        if (grant[1]) begin
            sel_addr = memfy_wb_addr;
            sel_val  = memfy_wb_val;
            sel_strb = memfy_wb_strb;
        end
        if (grant[2]) begin
            sel_addr = csr_wb_addr;
            sel_val  = csr_wb_val;
            sel_strb = '1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rf_rd_wr   <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_val  <= '0;
            rf_rd_strb <= '0;
        end else begin
            rf_rd_wr <= any_grant && (sel_addr != 5'd0);
            if (any_grant) begin
                rf_rd_addr <= sel_addr;
                rf_rd_val  <= sel_val;
                rf_rd_strb <= sel_strb;
            end
        end
    end

    function automatic logic tracked(input logic [4:0] addr);
        return (addr != 5'd0) && ((RV32E == 0) || !addr[4]);
    endfunction

    // Clear first, then set, so a same-edge issue of the committing register wins.
    always_comb begin
        pending_nxt = pending;
        if (rf_rd_wr && tracked(rf_rd_addr))        pending_nxt[rf_rd_addr]    = 1'b0;
        if (issue_valid && tracked(issue_rd_addr))  pending_nxt[issue_rd_addr] = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) pending <= '0;
        else          pending <= pending_nxt;
    end

    assign chk_hazard = pending[chk_rs1_addr] | pending[chk_rs2_addr] | pending[chk_rd_addr];
    assign sb_empty   = ~|pending;

endmodule

// File: tb/tb_friscv_rd_arbiter.sv
// Directed bench for friscv_rd_arbiter: reset, hazard tracking, arbitration order,
// strobes, same-edge set/clear, x0 writes and mid-operation reset.
module tb_friscv_rd_arbiter;
    localparam int XLEN = 32;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            issue_valid;
    logic [4:0]      issue_rd_addr;
    logic [4:0]      chk_rs1_addr, chk_rs2_addr, chk_rd_addr;
    logic            chk_hazard, sb_empty;
    logic            alu_wb_valid, alu_wb_ready;
    logic [4:0]      alu_wb_addr;
    logic [XLEN-1:0] alu_wb_val;
    logic [3:0]      alu_wb_strb;
    logic            memfy_wb_valid, memfy_wb_ready;
    logic [4:0]      memfy_wb_addr;
    logic [XLEN-1:0] memfy_wb_val;
    logic [3:0]      memfy_wb_strb;
    logic            csr_wb_valid, csr_wb_ready;
    logic [4:0]      csr_wb_addr;
    logic [XLEN-1:0] csr_wb_val;
    logic            rf_rd_wr;
    logic [4:0]      rf_rd_addr;
    logic [XLEN-1:0] rf_rd_val;
    logic [3:0]      rf_rd_strb;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    friscv_rd_arbiter #(.XLEN(XLEN), .RV32E(0)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr),
        .chk_rs1_addr(chk_rs1_addr), .chk_rs2_addr(chk_rs2_addr), .chk_rd_addr(chk_rd_addr),
        .chk_hazard(chk_hazard), .sb_empty(sb_empty),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_addr(alu_wb_addr),
        .alu_wb_val(alu_wb_val), .alu_wb_strb(alu_wb_strb),
        .memfy_wb_valid(memfy_wb_valid), .memfy_wb_ready(memfy_wb_ready), .memfy_wb_addr(memfy_wb_addr),
        .memfy_wb_val(memfy_wb_val), .memfy_wb_strb(memfy_wb_strb),
        .csr_wb_valid(csr_wb_valid), .csr_wb_ready(csr_wb_ready), .csr_wb_addr(csr_wb_addr),
        .csr_wb_val(csr_wb_val),
        .rf_rd_wr(rf_rd_wr), .rf_rd_addr(rf_rd_addr), .rf_rd_val(rf_rd_val), .rf_rd_strb(rf_rd_strb)
    );

    // Clock and watchdog
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change on the falling edge
    task automatic drive_idle();
        issue_valid = 1'b0; issue_rd_addr = '0;
        chk_rs1_addr = '0; chk_rs2_addr = '0; chk_rd_addr = '0;
        alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_val = '0; alu_wb_strb = '0;
        memfy_wb_valid = 1'b0; memfy_wb_addr = '0; memfy_wb_val = '0; memfy_wb_strb = '0;
        csr_wb_valid = 1'b0; csr_wb_addr = '0; csr_wb_val = '0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        drive_idle();
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] rdy;
        @(negedge aclk);
        aresetn = 1'b0;
        issue_valid = 1'b1; issue_rd_addr = 5'd3; chk_rs1_addr = 5'd3;
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd1;
        memfy_wb_valid = 1'b1; memfy_wb_addr = 5'd2;
        csr_wb_valid = 1'b1; csr_wb_addr = 5'd3;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        rdy = {csr_wb_ready, memfy_wb_ready, alu_wb_ready};
        checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b exp 000", rdy); end
        checks++; if (rf_rd_wr !== 1'b0) begin errors++; $display("FAIL reset_rf_wr: got %b exp 0", rf_rd_wr); end
        checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rf_addr: got %0d exp 0", rf_rd_addr); end
        checks++; if (rf_rd_val !== 32'h0) begin errors++; $display("FAIL reset_rf_val: got %h exp 0", rf_rd_val); end
        checks++; if (rf_rd_strb !== 4'h0) begin errors++; $display("FAIL reset_rf_strb: got %h exp 0", rf_rd_strb); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty: got %b exp 1", sb_empty); end
        checks++; if (chk_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b exp 0", chk_hazard); end
        drive_idle();
        aresetn = 1'b1;
    endtask

    task automatic test_issue_alu();
        @(negedge aclk);
        issue_valid = 1'b1; issue_rd_addr = 5'd5;
        @(negedge aclk);
        issue_valid = 1'b0; chk_rs1_addr = 5'd5;
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_val = 32'hDEADBEEF; alu_wb_strb = 4'hF;
        #1;
        checks++; if (chk_hazard !== 1'b1) begin errors++; $display("FAIL issue_hazard_set: got %b exp 1", chk_hazard); end
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL issue_sb_busy: got %b exp 0", sb_empty); end
        checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b exp 1", alu_wb_ready); end
        @(negedge aclk);
        alu_wb_valid = 1'b0;
        #1;
        checks++; if (rf_rd_wr !== 1'b1) begin errors++; $display("FAIL alu_rf_wr: got %b exp 1", rf_rd_wr); end
        checks++; if (rf_rd_addr !== 5'd5) begin errors++; $display("FAIL alu_rf_addr: got %0d exp 5", rf_rd_addr); end
        checks++; if (rf_rd_val !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_rf_val: got %h exp deadbeef", rf_rd_val); end
        checks++; if (rf_rd_strb !== 4'hF) begin errors++; $display("FAIL alu_rf_strb: got %h exp f", rf_rd_strb); end
        checks++; if (chk_hazard !== 1'b1) begin errors++; $display("FAIL alu_hazard_held: got %b exp 1", chk_hazard); end
        @(negedge aclk);
        #1;
        checks++; if (chk_hazard !== 1'b0) begin errors++; $display("FAIL alu_hazard_clear: got %b exp 0", chk_hazard); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL alu_sb_empty: got %b exp 1", sb_empty); end
        checks++; if (rf_rd_wr !== 1'b0) begin errors++; $display("FAIL alu_rf_pulse: got %b exp 0", rf_rd_wr); end
        chk_rs1_addr = '0;
    endtask

    task automatic test_arbitration();
        logic [2:0] rdy, exp_g;
        logic [4:0] exp_a;
        do_reset();
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd1; alu_wb_val = 32'h11; alu_wb_strb = 4'hF;
        memfy_wb_valid = 1'b1; memfy_wb_addr = 5'd2; memfy_wb_val = 32'h22; memfy_wb_strb = 4'hF;
        csr_wb_valid = 1'b1; csr_wb_addr = 5'd3; csr_wb_val = 32'h33;
        for (int i = 0; i < 6; i++) begin
            #1;
`ifdef FRISCV_RR_ARB_EN
            exp_g = 3'b001 << (i % 3);
            exp_a = 5'((i % 3) + 1);
`else
            exp_g = 3'b100;
            exp_a = 5'd3;
`endif
            rdy = {csr_wb_ready, memfy_wb_ready, alu_wb_ready};
            checks++; if (rdy !== exp_g) begin errors++; $display("FAIL arb_grant[%0d]: got %b exp %b", i, rdy, exp_g); end
            if (i > 0) begin
                exp_a = exp_q.pop_front();
                checks++; if (rf_rd_wr !== 1'b1 || rf_rd_addr !== exp_a) begin
                    errors++; $display("FAIL arb_rf[%0d]: got wr=%b addr=%0d exp wr=1 addr=%0d", i, rf_rd_wr, rf_rd_addr, exp_a);
                end
            end
`ifdef FRISCV_RR_ARB_EN
            exp_q.push_back(5'((i % 3) + 1));
`else
            exp_q.push_back(5'd3);
`endif
            @(negedge aclk);
        end
        drive_idle();
        #1;
        exp_a = exp_q.pop_front();
        checks++; if (rf_rd_wr !== 1'b1 || rf_rd_addr !== exp_a) begin
            errors++; $display("FAIL arb_rf_last: got wr=%b addr=%0d exp wr=1 addr=%0d", rf_rd_wr, rf_rd_addr, exp_a);
        end
    endtask

    task automatic test_strobes();
        @(negedge aclk);
        memfy_wb_valid = 1'b1; memfy_wb_addr = 5'd7; memfy_wb_val = 32'h000000AB; memfy_wb_strb = 4'h1;
        #1;
        checks++; if (memfy_wb_ready !== 1'b1) begin errors++; $display("FAIL memfy_ready: got %b exp 1", memfy_wb_ready); end
        @(negedge aclk);
        memfy_wb_valid = 1'b0;
        csr_wb_valid = 1'b1; csr_wb_addr = 5'd4; csr_wb_val = 32'h12345678;
        #1;
        checks++; if (rf_rd_strb !== 4'h1) begin errors++; $display("FAIL memfy_strb: got %h exp 1", rf_rd_strb); end
        checks++; if (rf_rd_val !== 32'h000000AB) begin errors++; $display("FAIL memfy_val: got %h exp 000000ab", rf_rd_val); end
        checks++; if (rf_rd_addr !== 5'd7) begin errors++; $display("FAIL memfy_addr: got %0d exp 7", rf_rd_addr); end
        @(negedge aclk);
        csr_wb_valid = 1'b0;
        #1;
        checks++; if (rf_rd_strb !== 4'hF) begin errors++; $display("FAIL csr_strb: got %h exp f", rf_rd_strb); end
        checks++; if (rf_rd_val !== 32'h12345678) begin errors++; $display("FAIL csr_val: got %h exp 12345678", rf_rd_val); end
    endtask

    task automatic test_set_clear();
        @(negedge aclk);
        issue_valid = 1'b1; issue_rd_addr = 5'd9;
        @(negedge aclk);
        issue_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd9; alu_wb_val = 32'h1; alu_wb_strb = 4'hF;
        @(negedge aclk);
        alu_wb_valid = 1'b0;
        #1;
        checks++; if (rf_rd_wr !== 1'b1 || rf_rd_addr !== 5'd9) begin
            errors++; $display("FAIL sc_commit: got wr=%b addr=%0d exp wr=1 addr=9", rf_rd_wr, rf_rd_addr);
        end
        issue_valid = 1'b1; issue_rd_addr = 5'd9;
        @(negedge aclk);
        issue_valid = 1'b0; chk_rd_addr = 5'd9;
        #1;
        checks++; if (chk_hazard !== 1'b1) begin errors++; $display("FAIL sc_set_wins: got %b exp 1", chk_hazard); end
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL sc_sb_busy: got %b exp 0", sb_empty); end
        alu_wb_valid = 1'b1;
        @(negedge aclk);
        alu_wb_valid = 1'b0;
        @(negedge aclk);
        #1;
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL sc_drain: got %b exp 1", sb_empty); end
        chk_rd_addr = '0;
    endtask

    task automatic test_x0();
        @(negedge aclk);
        issue_valid = 1'b1; issue_rd_addr = 5'd12;
        @(negedge aclk);
        issue_valid = 1'b0;
        csr_wb_valid = 1'b1; csr_wb_addr = 5'd0; csr_wb_val = 32'hFFFF;
        #1;
        checks++; if (csr_wb_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b exp 1", csr_wb_ready); end
        @(negedge aclk);
        csr_wb_valid = 1'b0; chk_rs2_addr = 5'd12;
        #1;
        checks++; if (rf_rd_wr !== 1'b0) begin errors++; $display("FAIL x0_no_write: got %b exp 0", rf_rd_wr); end
        checks++; if (chk_hazard !== 1'b1) begin errors++; $display("FAIL x0_pending_kept: got %b exp 1", chk_hazard); end
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd12; alu_wb_val = 32'h5; alu_wb_strb = 4'hF;
        @(negedge aclk);
        alu_wb_valid = 1'b0;
        issue_valid = 1'b1; issue_rd_addr = 5'd0;
        @(negedge aclk);
        issue_valid = 1'b0;
        #1;
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL x0_issue_ignored: got %b exp 1", sb_empty); end
        checks++; if (chk_hazard !== 1'b0) begin errors++; $display("FAIL x0_hazard_clear: got %b exp 0", chk_hazard); end
        chk_rs2_addr = '0;
    endtask

    task automatic test_mid_reset();
        @(negedge aclk);
        issue_valid = 1'b1; issue_rd_addr = 5'd6;
        @(negedge aclk);
        issue_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd6; alu_wb_val = 32'hCAFE; alu_wb_strb = 4'hF;
        @(negedge aclk);
        alu_wb_valid = 1'b0;
        issue_valid = 1'b1; issue_rd_addr = 5'd8;
        #1;
        checks++; if (rf_rd_wr !== 1'b1) begin errors++; $display("FAIL mr_inflight: got %b exp 1", rf_rd_wr); end
        aresetn = 1'b0;
        @(negedge aclk);
        issue_valid = 1'b0;
        #1;
        checks++; if (rf_rd_wr !== 1'b0 || rf_rd_addr !== 5'd0) begin
            errors++; $display("FAIL mr_rf_cleared: got wr=%b addr=%0d exp wr=0 addr=0", rf_rd_wr, rf_rd_addr);
        end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL mr_sb_empty: got %b exp 1", sb_empty); end
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0;
        drive_idle();
        test_reset();
        test_issue_alu();
        test_arbitration();
        test_strobes();
        test_set_clear();
        test_x0();
        test_mid_reset();
        repeat (2) @(negedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
